// File: rtl/riscv_pkg.sv
// Shared constants for the RV32I core: datapath width, reset vector, bubble encoding.
package riscv_pkg;

    localparam int unsigned XLEN      = 32;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int unsigned PC_STEP   = 4;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pipe_reg.sv
// Pipeline register field: synchronous reset, flush-to-constant, load enable.
module pipe_reg #(
    parameter int unsigned   W         = 32,
    parameter logic [W-1:0]  RST_VAL   = '0,
    parameter logic [W-1:0]  FLUSH_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         flush,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RST_VAL;
        end else if (flush) begin
            q <= FLUSH_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC register, imem address, IF/ID pipeline register and
// stall/flush event counters.
module if_stage
    import riscv_pkg::*;
#(
    parameter int unsigned     XLEN      = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC  = XLEN'(riscv_pkg::RESET_PC),
    parameter logic [31:0]     NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            if_id_flush,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_pc4,
    output logic [31:0]     if_id_instr,
    output logic            if_id_valid,
    output logic [31:0]     stall_count,
    output logic [31:0]     flush_count
);

    localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            pc_fields_en;

    assign pc_plus4  = pc + STEP;
    assign imem_addr = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= {redirect_pc[XLEN-1:2], 2'b00};
        end else if (!stall) begin
            pc <= pc_plus4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall)       stall_count <= stall_count + 32'd1;
            if (if_id_flush) flush_count <= flush_count + 32'd1;
        end
    end

    // On flush the PC fields still capture the current pc (debug aid), so they
    // load through the enable path rather than a constant flush value.
    assign pc_fields_en = !stall || if_id_flush;

    pipe_reg #(.W(XLEN), .RST_VAL('0), .FLUSH_VAL('0)) u_if_id_pc (
        .clk   (clk),
        .rst   (rst),
        .en    (pc_fields_en),
        .flush (1'b0),
        .d     (pc),
        .q     (if_id_pc)
    );

    pipe_reg #(.W(XLEN), .RST_VAL('0), .FLUSH_VAL('0)) u_if_id_pc4 (
        .clk   (clk),
        .rst   (rst),
        .en    (pc_fields_en),
        .flush (1'b0),
        .d     (pc_plus4),
        .q     (if_id_pc4)
    );

    pipe_reg #(.W(32), .RST_VAL(NOP_INSTR), .FLUSH_VAL(NOP_INSTR)) u_if_id_instr (
        .clk   (clk),
        .rst   (rst),
        .en    (!stall),
        .flush (if_id_flush),
        .d     (imem_rdata),
        .q     (if_id_instr)
    );

    pipe_reg #(.W(1), .RST_VAL(1'b0), .FLUSH_VAL(1'b0)) u_if_id_valid (
        .clk   (clk),
        .rst   (rst),
        .en    (!stall),
        .flush (if_id_flush),
        .d     (1'b1),
        .q     (if_id_valid)
    );

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: stimulus pushes expected post-edge state, monitor pops and compares.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        if_id_flush = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic [31:0] stall_count;
    logic [31:0] flush_count;

    always #5 clk = ~clk;

    assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

    if_stage #(.XLEN(32), .RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0013)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .if_id_flush    (if_id_flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .if_id_pc       (if_id_pc),
        .if_id_pc4      (if_id_pc4),
        .if_id_instr    (if_id_instr),
        .if_id_valid    (if_id_valid),
        .stall_count    (stall_count),
        .flush_count    (flush_count)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ipc;
        logic [31:0] ipc4;
        logic [31:0] instr;
        logic        valid;
        logic [31:0] sc;
        logic [31:0] fc;
        string       tag;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   pushed = 0;
    int   popped = 0;

    // Reference model state (value after the most recent edge).
    logic [31:0] m_pc = 32'h0, m_ipc = 32'h0, m_ipc4 = 32'h0, m_instr = 32'h13;
    logic        m_valid = 1'b0;
    logic [31:0] m_sc = 32'h0, m_fc = 32'h0;

    task automatic chk(input string name, input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s/%s actual=%h expected=%h", tag, name, act, exp);
        end
    endtask

    task automatic step(input string tag, input logic r, input logic s, input logic f,
                        input logic rv, input logic [31:0] rpc);
        exp_t e;
        logic [31:0] n_pc, n_ipc, n_ipc4, n_instr, n_sc, n_fc;
        logic        n_valid;
        @(negedge clk);
        rst = r; stall = s; if_id_flush = f; redirect_valid = rv; redirect_pc = rpc;
        if (r) begin
            n_pc = 32'h0; n_ipc = 32'h0; n_ipc4 = 32'h0; n_instr = 32'h13;
            n_valid = 1'b0; n_sc = 32'h0; n_fc = 32'h0;
        end else begin
            n_pc = rv ? (rpc & 32'hFFFF_FFFC) : (s ? m_pc : m_pc + 32'd4);
            if (f) begin
                n_ipc = m_pc; n_ipc4 = m_pc + 32'd4; n_instr = 32'h13; n_valid = 1'b0;
            end else if (s) begin
                n_ipc = m_ipc; n_ipc4 = m_ipc4; n_instr = m_instr; n_valid = m_valid;
            end else begin
                n_ipc = m_pc; n_ipc4 = m_pc + 32'd4; n_instr = m_pc ^ 32'hA5A5_0000; n_valid = 1'b1;
            end
            n_sc = m_sc + (s ? 32'd1 : 32'd0);
            n_fc = m_fc + (f ? 32'd1 : 32'd0);
        end
        m_pc = n_pc; m_ipc = n_ipc; m_ipc4 = n_ipc4; m_instr = n_instr;
        m_valid = n_valid; m_sc = n_sc; m_fc = n_fc;
        e.pc = n_pc; e.ipc = n_ipc; e.ipc4 = n_ipc4; e.instr = n_instr;
        e.valid = n_valid; e.sc = n_sc; e.fc = n_fc; e.tag = tag;
        q.push_back(e);
        pushed++;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                popped++;
                chk("imem_addr",   e.tag, imem_addr,   e.pc);
                chk("if_id_pc",    e.tag, if_id_pc,    e.ipc);
                chk("if_id_pc4",   e.tag, if_id_pc4,   e.ipc4);
                chk("if_id_instr", e.tag, if_id_instr, e.instr);
                chk("if_id_valid", e.tag, {31'b0, if_id_valid}, {31'b0, e.valid});
                chk("stall_count", e.tag, stall_count, e.sc);
                chk("flush_count", e.tag, flush_count, e.fc);
            end
        end
    end

    initial begin : stimulus
        int guard;
        step("reset",     1, 0, 0, 0, 32'h0);
        step("reset",     1, 0, 0, 0, 32'h0);
        // free run from reset: fetch 0,4 then stall with pc=8
        step("free",      0, 0, 0, 0, 32'h0);
        step("free",      0, 0, 0, 0, 32'h0);
        repeat (3) step("stall", 0, 1, 0, 0, 32'h0);
        step("free",      0, 0, 0, 0, 32'h0);
        step("free",      0, 0, 0, 0, 32'h0);
        // redirect to unaligned target with flush
        step("redir_fl",  0, 0, 1, 1, 32'h0000_0103);
        step("free",      0, 0, 0, 0, 32'h0);
        step("free",      0, 0, 0, 0, 32'h0);
        // redirect without flush: wrong-path word enters valid
        step("redir",     0, 0, 0, 1, 32'h0000_0200);
        // stall + flush + redirect together
        step("all3",      0, 1, 1, 1, 32'h0000_0040);
        step("free",      0, 0, 0, 0, 32'h0);
        // flush alone while free running
        step("flush",     0, 0, 1, 0, 32'h0);
        // stall + flush without redirect
        step("stall_fl",  0, 1, 1, 0, 32'h0);
        // address-space wrap
        step("to_top",    0, 0, 0, 1, 32'hFFFF_FFFE);
        step("wrap",      0, 0, 0, 0, 32'h0);
        step("wrap",      0, 0, 0, 0, 32'h0);
        step("wrap",      0, 0, 0, 0, 32'h0);
        // redirect while stalled
        step("st_redir",  0, 1, 0, 1, 32'h0000_0500);
        // reset during stall + redirect + flush
        step("st",        0, 1, 0, 0, 32'h0);
        step("rst_mid",   1, 1, 1, 1, 32'h0000_0800);
        step("post_rst",  0, 0, 0, 0, 32'h0);
        step("post_rst",  0, 0, 0, 0, 32'h0);
        @(negedge clk);
        rst = 0; stall = 0; if_id_flush = 0; redirect_valid = 0;
        guard = 0;
        while (q.size() > 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (q.size() != 0 || popped != pushed) begin
            failures++;
            $display("FAIL drain popped=%0d required=%0d", popped, pushed);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
